// File: rtl/fifo2_tx_rx.sv
// Command/response bridge between a 34-bit FIFO pair and one serial TX core plus one RX core.
// Commands become register-write strobes for the selected channel; core events become response words.
module fifo2_tx_rx (
  input  logic        clk,
  input  logic        rst,
  input  logic        fifo_read_empty,
  input  logic [33:0] fifo_read_data,
  output logic        fifo_read_inc,
  input  logic        fifo_write_full,
  output logic [33:0] fifo_write_data,
  output logic        fifo_write_inc,
  output logic [31:0] wr_data_tx,
  output logic        data_we_tx,
  output logic [15:0] wr_config_tx,
  output logic        config_we_tx,
  input  logic        rd_status_tx,
  input  logic [15:0] rd_config_tx,
  input  logic        config_changed_tx,
  input  logic        status_changed_tx,
  output logic [15:0] wr_config_rx,
  output logic        config_we_rx,
  input  logic [15:0] rd_status_rx,
  input  logic [15:0] rd_config_rx,
  input  logic [31:0] rd_data_rx,
  input  logic        config_changed_rx,
  input  logic        data_status_changed_rx
);

  typedef enum logic [1:0] {
    ADDR_CFG  = 2'd0,
    ADDR_DATA = 2'd1,
    ADDR_STAT = 2'd2,
    ADDR_CHAN = 2'd3
  } addr_e;

  logic        rd_inc_q, rd_inc_d;
  logic        cfg_we_tx_q, cfg_we_tx_d, dat_we_tx_q, dat_we_tx_d, cfg_we_rx_q, cfg_we_rx_d;
  logic [31:0] wr_dat_tx_q, wr_dat_tx_d;
  logic [15:0] wr_cfg_tx_q, wr_cfg_tx_d, wr_cfg_rx_q, wr_cfg_rx_d;
  logic        chan_q, chan_d;
  logic        echo_pend_q, echo_pend_d, echo_val_q, echo_val_d;
  logic        cfg_pend_q, cfg_pend_d;
  logic [15:0] cfg_val_q, cfg_val_d;
  logic        dat_pend_q, dat_pend_d;
  logic [31:0] dat_val_q, dat_val_d;
  logic        sts_pend_q, sts_pend_d;
  logic [31:0] sts_val_q, sts_val_d;
  logic        sts_first_q, sts_first_d;
  logic        wr_inc_q, wr_inc_d;
  logic [33:0] wr_word_q, wr_word_d;
  addr_e       cmd_addr;
  logic        pop;

  assign cmd_addr = addr_e'(fifo_read_data[33:32]);
  assign pop      = !fifo_read_empty && !rd_inc_q;

  always_comb begin
    rd_inc_d    = 1'b0;
    cfg_we_tx_d = 1'b0;
    dat_we_tx_d = 1'b0;
    cfg_we_rx_d = 1'b0;
    wr_dat_tx_d = wr_dat_tx_q;
    wr_cfg_tx_d = wr_cfg_tx_q;
    wr_cfg_rx_d = wr_cfg_rx_q;
    chan_d      = chan_q;
    echo_pend_d = echo_pend_q;
    echo_val_d  = echo_val_q;
    cfg_pend_d  = cfg_pend_q;
    cfg_val_d   = cfg_val_q;
    dat_pend_d  = dat_pend_q;
    dat_val_d   = dat_val_q;
    sts_pend_d  = sts_pend_q;
    sts_val_d   = sts_val_q;
    sts_first_d = sts_first_q;
    wr_inc_d    = 1'b0;
    wr_word_d   = wr_word_q;

    // Event capture: only the selected channel; a re-trigger overwrites the snapshot.
    if (!chan_q) begin
      if (config_changed_tx) begin
        cfg_pend_d = 1'b1;
        cfg_val_d  = rd_config_tx;
      end
      if (status_changed_tx) begin
        sts_pend_d = 1'b1;
        sts_val_d  = {31'b0, rd_status_tx};
      end
    end else begin
      if (config_changed_rx) begin
        cfg_pend_d = 1'b1;
        cfg_val_d  = rd_config_rx;
      end
      if (data_status_changed_rx) begin
        dat_pend_d = 1'b1;
        dat_val_d  = rd_data_rx;
        sts_pend_d = 1'b1;
        sts_val_d  = {16'b0, rd_status_rx};
      end
    end

    // Drain: events bypass straight to the output; the echo waits one cycle after its pop.
    if (!fifo_write_full) begin
      if (sts_first_q && sts_pend_d) begin
        wr_inc_d    = 1'b1;
        wr_word_d   = {ADDR_STAT, sts_val_d};
        sts_pend_d  = 1'b0;
        sts_first_d = 1'b0;
      end else if (echo_pend_q) begin
        wr_inc_d    = 1'b1;
        wr_word_d   = {ADDR_CHAN, 31'b0, echo_val_q};
        echo_pend_d = 1'b0;
      end else if (cfg_pend_d) begin
        wr_inc_d   = 1'b1;
        wr_word_d  = {ADDR_CFG, 16'b0, cfg_val_d};
        cfg_pend_d = 1'b0;
      end else if (dat_pend_d) begin
        wr_inc_d    = 1'b1;
        wr_word_d   = {ADDR_DATA, dat_val_d};
        dat_pend_d  = 1'b0;
        sts_first_d = sts_pend_d;
      end else if (sts_pend_d) begin
        wr_inc_d    = 1'b1;
        wr_word_d   = {ADDR_STAT, sts_val_d};
        sts_pend_d  = 1'b0;
        sts_first_d = 1'b0;
      end
    end

    if (pop) begin
      rd_inc_d = 1'b1;
      unique case (cmd_addr)
        ADDR_CFG: begin
          if (!chan_q) begin
            cfg_we_tx_d = 1'b1;
            wr_cfg_tx_d = fifo_read_data[15:0];
          end else begin
            cfg_we_rx_d = 1'b1;
            wr_cfg_rx_d = fifo_read_data[15:0];
          end
        end
        ADDR_DATA: begin
          if (!chan_q) begin
            dat_we_tx_d = 1'b1;
            wr_dat_tx_d = fifo_read_data[31:0];
          end
        end
        ADDR_STAT: ;
        ADDR_CHAN: begin
          chan_d      = fifo_read_data[0];
          echo_pend_d = 1'b1;
          echo_val_d  = fifo_read_data[0];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_inc_q    <= 1'b0;
      cfg_we_tx_q <= 1'b0;
      dat_we_tx_q <= 1'b0;
      cfg_we_rx_q <= 1'b0;
      wr_dat_tx_q <= '0;
      wr_cfg_tx_q <= '0;
      wr_cfg_rx_q <= '0;
      chan_q      <= 1'b0;
      echo_pend_q <= 1'b0;
      echo_val_q  <= 1'b0;
      cfg_pend_q  <= 1'b0;
      cfg_val_q   <= '0;
      dat_pend_q  <= 1'b0;
      dat_val_q   <= '0;
      sts_pend_q  <= 1'b0;
      sts_val_q   <= '0;
      sts_first_q <= 1'b0;
      wr_inc_q    <= 1'b0;
      wr_word_q   <= '0;
    end else begin
      rd_inc_q    <= rd_inc_d;
      cfg_we_tx_q <= cfg_we_tx_d;
      dat_we_tx_q <= dat_we_tx_d;
      cfg_we_rx_q <= cfg_we_rx_d;
      wr_dat_tx_q <= wr_dat_tx_d;
      wr_cfg_tx_q <= wr_cfg_tx_d;
      wr_cfg_rx_q <= wr_cfg_rx_d;
      chan_q      <= chan_d;
      echo_pend_q <= echo_pend_d;
      echo_val_q  <= echo_val_d;
      cfg_pend_q  <= cfg_pend_d;
      cfg_val_q   <= cfg_val_d;
      dat_pend_q  <= dat_pend_d;
      dat_val_q   <= dat_val_d;
      sts_pend_q  <= sts_pend_d;
      sts_val_q   <= sts_val_d;
      sts_first_q <= sts_first_d;
      wr_inc_q    <= wr_inc_d;
      wr_word_q   <= wr_word_d;
    end
  end

  assign fifo_read_inc   = rd_inc_q;
  assign config_we_tx    = cfg_we_tx_q;
  assign data_we_tx      = dat_we_tx_q;
  assign config_we_rx    = cfg_we_rx_q;
  assign wr_data_tx      = wr_dat_tx_q;
  assign wr_config_tx    = wr_cfg_tx_q;
  assign wr_config_rx    = wr_cfg_rx_q;
  assign fifo_write_inc  = wr_inc_q;
  assign fifo_write_data = wr_word_q;

endmodule

// File: tb/tb_fifo2_tx_rx.sv
// Bench for fifo2_tx_rx: directed scenarios, then random traffic against a slot-based reference model.
module tb_fifo2_tx_rx;
  logic        clk = 1'b0;
  logic        rst;
  logic        fifo_read_empty;
  logic [33:0] fifo_read_data;
  logic        fifo_read_inc;
  logic        fifo_write_full;
  logic [33:0] fifo_write_data;
  logic        fifo_write_inc;
  logic [31:0] wr_data_tx;
  logic        data_we_tx;
  logic [15:0] wr_config_tx;
  logic        config_we_tx;
  logic        rd_status_tx;
  logic [15:0] rd_config_tx;
  logic        config_changed_tx;
  logic        status_changed_tx;
  logic [15:0] wr_config_rx;
  logic        config_we_rx;
  logic [15:0] rd_status_rx;
  logic [15:0] rd_config_rx;
  logic [31:0] rd_data_rx;
  logic        config_changed_rx;
  logic        data_status_changed_rx;

  int n_vec = 0;
  int n_err = 0;

  fifo2_tx_rx dut (
    .clk(clk), .rst(rst),
    .fifo_read_empty(fifo_read_empty), .fifo_read_data(fifo_read_data), .fifo_read_inc(fifo_read_inc),
    .fifo_write_full(fifo_write_full), .fifo_write_data(fifo_write_data), .fifo_write_inc(fifo_write_inc),
    .wr_data_tx(wr_data_tx), .data_we_tx(data_we_tx), .wr_config_tx(wr_config_tx), .config_we_tx(config_we_tx),
    .rd_status_tx(rd_status_tx), .rd_config_tx(rd_config_tx),
    .config_changed_tx(config_changed_tx), .status_changed_tx(status_changed_tx),
    .wr_config_rx(wr_config_rx), .config_we_rx(config_we_rx),
    .rd_status_rx(rd_status_rx), .rd_config_rx(rd_config_rx), .rd_data_rx(rd_data_rx),
    .config_changed_rx(config_changed_rx), .data_status_changed_rx(data_status_changed_rx)
  );

  always #5 clk = ~clk;

  // Reference model: pending responses kept in a table indexed by response address.
  logic        m_chan, m_rd_inc, m_cfg_we_tx, m_dat_we_tx, m_cfg_we_rx, m_wr_inc, m_owe;
  logic [31:0] m_wr_dat_tx;
  logic [15:0] m_wr_cfg_tx, m_wr_cfg_rx;
  logic [33:0] m_wr_word;
  bit          m_pv [4];
  logic [31:0] m_pval [4];

  always @(posedge clk) begin
    int pick;
    if (rst) begin
      m_chan = 0; m_rd_inc = 0; m_cfg_we_tx = 0; m_dat_we_tx = 0; m_cfg_we_rx = 0;
      m_wr_inc = 0; m_owe = 0; m_wr_dat_tx = 0; m_wr_cfg_tx = 0; m_wr_cfg_rx = 0; m_wr_word = 0;
      for (int i = 0; i < 4; i++) begin m_pv[i] = 0; m_pval[i] = 0; end
    end else begin
      if (m_chan == 0) begin
        if (config_changed_tx) begin m_pv[0] = 1; m_pval[0] = 32'(rd_config_tx); end
        if (status_changed_tx) begin m_pv[2] = 1; m_pval[2] = 32'(rd_status_tx); end
      end else begin
        if (config_changed_rx) begin m_pv[0] = 1; m_pval[0] = 32'(rd_config_rx); end
        if (data_status_changed_rx) begin
          m_pv[1] = 1; m_pval[1] = rd_data_rx;
          m_pv[2] = 1; m_pval[2] = 32'(rd_status_rx);
        end
      end
      m_wr_inc = 0;
      if (!fifo_write_full) begin
        pick = -1;
        if (m_owe && m_pv[2]) pick = 2;
        else if (m_pv[3]) pick = 3;
        else if (m_pv[0]) pick = 0;
        else if (m_pv[1]) pick = 1;
        else if (m_pv[2]) pick = 2;
        if (pick >= 0) begin
          m_wr_inc  = 1;
          m_wr_word = {2'(pick), m_pval[pick]};
          m_pv[pick] = 0;
          if (pick == 1) m_owe = m_pv[2];
          if (pick == 2) m_owe = 0;
        end
      end
      m_cfg_we_tx = 0; m_dat_we_tx = 0; m_cfg_we_rx = 0;
      if (!fifo_read_empty && !m_rd_inc) begin
        m_rd_inc = 1;
        case (fifo_read_data[33:32])
          2'd0: if (m_chan == 0) begin m_cfg_we_tx = 1; m_wr_cfg_tx = fifo_read_data[15:0]; end
                else begin m_cfg_we_rx = 1; m_wr_cfg_rx = fifo_read_data[15:0]; end
          2'd1: if (m_chan == 0) begin m_dat_we_tx = 1; m_wr_dat_tx = fifo_read_data[31:0]; end
          2'd3: begin m_chan = fifo_read_data[0]; m_pv[3] = 1; m_pval[3] = {31'b0, fifo_read_data[0]}; end
          default: ;
        endcase
      end else m_rd_inc = 0;
    end
  end

  task automatic idle_inputs();
    fifo_read_empty = 1; fifo_read_data = 0; fifo_write_full = 0;
    rd_status_tx = 0; rd_config_tx = 0; config_changed_tx = 0; status_changed_tx = 0;
    rd_status_rx = 0; rd_config_rx = 0; rd_data_rx = 0; config_changed_rx = 0; data_status_changed_rx = 0;
  endtask

  // Presents one command for exactly one sampling edge; returns #1 after that edge.
  task automatic cmd(input logic [1:0] a, input logic [31:0] p);
    @(posedge clk); #1;
    fifo_read_empty = 0; fifo_read_data = {a, p};
    @(posedge clk); #1;
    fifo_read_empty = 1;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1; idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({fifo_read_inc, fifo_write_inc, data_we_tx, config_we_tx, config_we_rx} !== 5'b0 ||
        fifo_write_data !== 34'd0 || wr_data_tx !== 32'd0 || wr_config_tx !== 16'd0 || wr_config_rx !== 16'd0) begin
      n_err++;
      $display("FAIL reset: outputs inc=%b winc=%b wd=%h wdtx=%h wctx=%h wcrx=%h, required all zero",
               fifo_read_inc, fifo_write_inc, fifo_write_data, wr_data_tx, wr_config_tx, wr_config_rx);
    end
    rst = 0;
  endtask

  task automatic test_tx_cmds();
    cmd(2'd0, 32'd87);
    n_vec++;
    if (fifo_read_inc !== 1 || config_we_tx !== 1 || wr_config_tx !== 16'd87 || data_we_tx !== 0) begin
      n_err++; $display("FAIL tx_cfg: inc=%b we=%b val=%0d, required 1 1 87", fifo_read_inc, config_we_tx, wr_config_tx);
    end
    step();
    n_vec++;
    if (fifo_read_inc !== 0 || config_we_tx !== 0 || wr_config_tx !== 16'd87) begin
      n_err++; $display("FAIL tx_cfg_pulse: inc=%b we=%b val=%0d, required 0 0 87 held", fifo_read_inc, config_we_tx, wr_config_tx);
    end
    cmd(2'd1, 32'd91);
    n_vec++;
    if (fifo_read_inc !== 1 || data_we_tx !== 1 || wr_data_tx !== 32'd91 || config_we_tx !== 0) begin
      n_err++; $display("FAIL tx_data: inc=%b we=%b val=%0d, required 1 1 91", fifo_read_inc, data_we_tx, wr_data_tx);
    end
    cmd(2'd2, 32'd99);
    n_vec++;
    if (fifo_read_inc !== 1 || {data_we_tx, config_we_tx, config_we_rx} !== 3'b0) begin
      n_err++; $display("FAIL tx_status: inc=%b strobes=%b, required 1 000", fifo_read_inc, {data_we_tx, config_we_tx, config_we_rx});
    end
  endtask

  task automatic test_rx_cmds();
    cmd(2'd3, 32'd1);
    n_vec++;
    if (fifo_read_inc !== 1 || {data_we_tx, config_we_tx, config_we_rx} !== 3'b0 || fifo_write_inc !== 0) begin
      n_err++; $display("FAIL chan_sel: inc=%b strobes=%b winc=%b, required 1 000 0", fifo_read_inc,
                        {data_we_tx, config_we_tx, config_we_rx}, fifo_write_inc);
    end
    step();
    n_vec++;
    if (fifo_write_inc !== 1 || fifo_write_data !== {2'd3, 32'd1}) begin
      n_err++; $display("FAIL echo_rx: winc=%b data=%h, required 1 %h", fifo_write_inc, fifo_write_data, {2'd3, 32'd1});
    end
    cmd(2'd0, 32'd88);
    n_vec++;
    if (config_we_rx !== 1 || wr_config_rx !== 16'd88 || config_we_tx !== 0) begin
      n_err++; $display("FAIL rx_cfg: we=%b val=%0d tx_we=%b, required 1 88 0", config_we_rx, wr_config_rx, config_we_tx);
    end
    cmd(2'd1, 32'd88);
    n_vec++;
    if (fifo_read_inc !== 1 || {data_we_tx, config_we_tx, config_we_rx} !== 3'b0) begin
      n_err++; $display("FAIL rx_data_cmd: inc=%b strobes=%b, required 1 000", fifo_read_inc, {data_we_tx, config_we_tx, config_we_rx});
    end
    cmd(2'd2, 32'd17);
    n_vec++;
    if (fifo_read_inc !== 1 || {data_we_tx, config_we_tx, config_we_rx} !== 3'b0) begin
      n_err++; $display("FAIL rx_stat_cmd: inc=%b strobes=%b, required 1 000", fifo_read_inc, {data_we_tx, config_we_tx, config_we_rx});
    end
  endtask

  task automatic test_rx_events();
    rd_config_rx = 16'd34; config_changed_rx = 1;
    step(); config_changed_rx = 0;
    n_vec++;
    if (fifo_write_inc !== 1 || fifo_write_data !== {2'd0, 32'd34}) begin
      n_err++; $display("FAIL rx_cfg_evt: winc=%b data=%h, required 1 %h", fifo_write_inc, fifo_write_data, {2'd0, 32'd34});
    end
    rd_data_rx = 32'd456791; rd_status_rx = 16'd76; data_status_changed_rx = 1;
    config_changed_tx = 1; rd_config_tx = 16'd5;
    step(); data_status_changed_rx = 0; config_changed_tx = 0; rd_data_rx = 0; rd_status_rx = 0;
    n_vec++;
    if (fifo_write_inc !== 1 || fifo_write_data !== {2'd1, 32'd456791}) begin
      n_err++; $display("FAIL rx_data_evt: winc=%b data=%h, required 1 %h", fifo_write_inc, fifo_write_data, {2'd1, 32'd456791});
    end
    step();
    n_vec++;
    if (fifo_write_inc !== 1 || fifo_write_data !== {2'd2, 32'd76}) begin
      n_err++; $display("FAIL rx_stat_evt: winc=%b data=%h, required 1 %h", fifo_write_inc, fifo_write_data, {2'd2, 32'd76});
    end
    step();
    n_vec++;
    if (fifo_write_inc !== 0) begin
      n_err++; $display("FAIL other_chan_drop: winc=%b, required 0", fifo_write_inc);
    end
  endtask

  task automatic test_full_hold();
    fifo_write_full = 1;
    rd_data_rx = 32'hCAFE_0001; rd_status_rx = 16'h0042; data_status_changed_rx = 1;
    step(); data_status_changed_rx = 0;
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (fifo_write_inc !== 0) begin
        n_err++; $display("FAIL full_hold[%0d]: winc=%b, required 0", i, fifo_write_inc);
      end
      step();
    end
    fifo_write_full = 0;
    step();
    n_vec++;
    if (fifo_write_inc !== 1 || fifo_write_data !== {2'd1, 32'hCAFE_0001}) begin
      n_err++; $display("FAIL full_release_data: winc=%b data=%h, required 1 %h", fifo_write_inc, fifo_write_data, {2'd1, 32'hCAFE_0001});
    end
    step();
    n_vec++;
    if (fifo_write_inc !== 1 || fifo_write_data !== {2'd2, 32'h42}) begin
      n_err++; $display("FAIL full_release_stat: winc=%b data=%h, required 1 %h", fifo_write_inc, fifo_write_data, {2'd2, 32'h42});
    end
  endtask

  task automatic test_tx_events();
    cmd(2'd3, 32'd0);
    n_vec++;
    if (fifo_write_inc !== 0) begin
      n_err++; $display("FAIL echo_early: winc=%b, required 0", fifo_write_inc);
    end
    step();
    n_vec++;
    if (fifo_write_inc !== 1 || fifo_write_data !== {2'd3, 32'd0}) begin
      n_err++; $display("FAIL echo_tx: winc=%b data=%h, required 1 %h", fifo_write_inc, fifo_write_data, {2'd3, 32'd0});
    end
    rd_config_tx = 16'd698; config_changed_tx = 1;
    step(); config_changed_tx = 0;
    n_vec++;
    if (fifo_write_inc !== 1 || fifo_write_data !== {2'd0, 32'd698}) begin
      n_err++; $display("FAIL tx_cfg_evt: winc=%b data=%h, required 1 %h", fifo_write_inc, fifo_write_data, {2'd0, 32'd698});
    end
    rd_status_tx = 1; status_changed_tx = 1;
    step(); status_changed_tx = 0;
    n_vec++;
    if (fifo_write_inc !== 1 || fifo_write_data !== {2'd2, 32'd1}) begin
      n_err++; $display("FAIL tx_stat_evt: winc=%b data=%h, required 1 %h", fifo_write_inc, fifo_write_data, {2'd2, 32'd1});
    end
  endtask

  task automatic test_mid_reset();
    cmd(2'd3, 32'd1);
    fifo_write_full = 1;
    rd_config_rx = 16'd9; config_changed_rx = 1;
    step(); config_changed_rx = 0;
    rst = 1; step(); rst = 0;
    fifo_write_full = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++;
      if (fifo_write_inc !== 0) begin
        n_err++; $display("FAIL mid_reset_drop[%0d]: winc=%b, required 0", i, fifo_write_inc);
      end
    end
    cmd(2'd0, 32'd5);
    n_vec++;
    if (config_we_tx !== 1 || config_we_rx !== 0 || wr_config_tx !== 16'd5) begin
      n_err++; $display("FAIL mid_reset_chan: tx_we=%b rx_we=%b val=%0d, required 1 0 5", config_we_tx, config_we_rx, wr_config_tx);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      fifo_read_empty = ($urandom_range(0, 1) == 0);
      fifo_read_data = {$urandom_range(0, 3) == 3 ? 2'd3 : 2'($urandom_range(0, 2)), $urandom()};
      fifo_write_full = ($urandom_range(0, 9) < 3);
      rd_status_tx = 1'($urandom());
      rd_config_tx = 16'($urandom());
      config_changed_tx = ($urandom_range(0, 5) == 0);
      status_changed_tx = ($urandom_range(0, 5) == 0);
      rd_status_rx = 16'($urandom());
      rd_config_rx = 16'($urandom());
      rd_data_rx = $urandom();
      config_changed_rx = ($urandom_range(0, 5) == 0);
      data_status_changed_rx = ($urandom_range(0, 5) == 0);
      @(negedge clk);
      n_vec++;
      if (fifo_read_inc !== m_rd_inc || config_we_tx !== m_cfg_we_tx || data_we_tx !== m_dat_we_tx ||
          config_we_rx !== m_cfg_we_rx || wr_config_tx !== m_wr_cfg_tx || wr_data_tx !== m_wr_dat_tx ||
          wr_config_rx !== m_wr_cfg_rx) begin
        n_err++;
        $display("FAIL rand_cmd[%0d]: inc/we=%b%b%b%b vals=%h %h %h, required %b%b%b%b %h %h %h", c,
                 fifo_read_inc, config_we_tx, data_we_tx, config_we_rx, wr_config_tx, wr_data_tx, wr_config_rx,
                 m_rd_inc, m_cfg_we_tx, m_dat_we_tx, m_cfg_we_rx, m_wr_cfg_tx, m_wr_dat_tx, m_wr_cfg_rx);
      end
      n_vec++;
      if (fifo_write_inc !== m_wr_inc || (m_wr_inc && fifo_write_data !== m_wr_word)) begin
        n_err++;
        $display("FAIL rand_resp[%0d]: winc=%b data=%h, required %b %h", c, fifo_write_inc, fifo_write_data, m_wr_inc, m_wr_word);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_tx_cmds();
    test_rx_cmds();
    test_rx_events();
    test_full_hold();
    test_tx_events();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
